pipe_ctrl_reg: RTL and testbench



---
 rtl/pipe_ctrl_reg.sv | 69 ++++++
 tb/tb_pipe_ctrl_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_reg.sv
// Pipeline-stage control register: carries a control bundle and valid bit
// across one boundary, with bubble insertion, miss freeze and perf counters.
module pipe_ctrl_reg #(
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_en,
  input  logic              flush_en,
  input  logic              d_cache_miss,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              flush_pending,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic do_freeze;
  logic do_bubble;

  always_comb begin
    do_freeze = d_cache_miss;
    do_bubble = !d_cache_miss && (stall_en || flush_en || flush_pending);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= BUBBLE_VAL;
      valid_out     <= 1'b0;
      flush_pending <= 1'b0;
      bubble_cnt    <= '0;
      freeze_cnt    <= '0;
    end else begin
      // A miss holds the stage but remembers any flush until the miss ends.
      if (do_freeze) begin
        if (flush_en) begin
          flush_pending <= 1'b1;
        end
      end else if (do_bubble) begin
        data_out      <= BUBBLE_VAL;
        valid_out     <= 1'b0;
        flush_pending <= 1'b0;
      end else begin
        data_out  <= data_in;
        valid_out <= valid_in;
      end

      if (cnt_clr) begin
        bubble_cnt <= '0;
        freeze_cnt <= '0;
      end else begin
        if (do_bubble && bubble_cnt != CNT_MAX) begin
          bubble_cnt <= bubble_cnt + 1'b1;
        end
        if (do_freeze && freeze_cnt != CNT_MAX) begin
          freeze_cnt <= freeze_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// Bench for pipe_ctrl_reg: vector table, directed corner sequences and a
// random phase, all checked through an expected-result queue.
module tb_pipe_ctrl_reg;

  localparam logic [7:0] BUB = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, stall_en, flush_en, d_cache_miss, valid_in, cnt_clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, flush_pending;
  logic [3:0] bubble_cnt, freeze_cnt;

  pipe_ctrl_reg #(.DATA_W(8), .BUBBLE_VAL(8'hA5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_en(stall_en), .flush_en(flush_en),
    .d_cache_miss(d_cache_miss), .data_in(data_in), .valid_in(valid_in),
    .cnt_clr(cnt_clr), .data_out(data_out), .valid_out(valid_out),
    .flush_pending(flush_pending), .bubble_cnt(bubble_cnt),
    .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       p;
    logic [3:0] b;
    logic [3:0] f;
  } exp_t;

  typedef struct {
    logic       s, f, m;
    logic [7:0] d;
    logic       v, c;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // reference state
  logic [7:0] m_d;
  logic       m_v, m_p;
  logic [3:0] m_b, m_f;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic r, s, f, m, c, input logic [7:0] d, input logic v);
    if (r) begin
      m_d = BUB; m_v = 1'b0; m_p = 1'b0; m_b = 4'd0; m_f = 4'd0;
    end else begin
      if (m) begin
        if (m_f != 4'hF) m_f = m_f + 4'd1;
        if (f) m_p = 1'b1;
      end else if (s || f || m_p) begin
        m_d = BUB; m_v = 1'b0; m_p = 1'b0;
        if (m_b != 4'hF) m_b = m_b + 4'd1;
      end else begin
        m_d = d; m_v = v;
      end
      if (c) begin
        m_b = 4'd0; m_f = 4'd0;
      end
    end
  endtask

  // Drive one cycle; expected value is the table entry when given, else the model.
  task automatic step(input string name, input logic r, s, f, m, c,
                      input logic [7:0] d, input logic v,
                      input logic use_tab, input exp_t tab);
    exp_t e, got;
    @(negedge clk);
    rst = r; stall_en = s; flush_en = f; d_cache_miss = m; cnt_clr = c;
    data_in = d; valid_in = v;
    model(r, s, f, m, c, d, v);
    if (use_tab) e = tab;
    else e = '{d: m_d, v: m_v, p: m_p, b: m_b, f: m_f};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      cmp({name, ".data_out"},      data_out,             got.d);
      cmp({name, ".valid_out"},     {7'd0, valid_out},    {7'd0, got.v});
      cmp({name, ".flush_pending"}, {7'd0, flush_pending},{7'd0, got.p});
      cmp({name, ".bubble_cnt"},    {4'd0, bubble_cnt},   {4'd0, got.b});
      cmp({name, ".freeze_cnt"},    {4'd0, freeze_cnt},   {4'd0, got.f});
    end
  endtask

  function automatic void addv(input logic s, f, m, input logic [7:0] d,
                               input logic v, c, input logic [7:0] ed,
                               input logic ev, ep, input logic [3:0] eb, ef);
    vec_t x;
    x.s = s; x.f = f; x.m = m; x.d = d; x.v = v; x.c = c;
    x.e = '{d: ed, v: ev, p: ep, b: eb, f: ef};
    vecs.push_back(x);
  endfunction

  exp_t none;

  initial begin
    none = '{d: 8'h00, v: 1'b0, p: 1'b0, b: 4'd0, f: 4'd0};
    rst = 1'b1; stall_en = 1'b0; flush_en = 1'b0; d_cache_miss = 1'b0;
    cnt_clr = 1'b0; data_in = 8'h00; valid_in = 1'b0;

    // s     f     m     data   v     clr   | data_out v    pend  bcnt   fcnt
    addv(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd0, 4'd0);
    addv(1'b0, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 4'd0, 4'd0);
    addv(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd0, 4'd0);
    addv(1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd1, 4'd0);
    addv(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd1, 4'd0);
    addv(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd1, 4'd1);
    addv(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 4'd1, 4'd2);
    addv(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 4'd1, 4'd3);
    addv(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 4'd1, 4'd4);
    addv(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd2, 4'd4);
    addv(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 4'd2, 4'd4);
    addv(1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 4'd2, 4'd5);
    addv(1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd3, 4'd5);
    addv(1'b0, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 4'd3, 4'd5);
    addv(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 4'd3, 4'd6);
    addv(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 4'd3, 4'd7);
    addv(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 4'd3, 4'd8);
    addv(1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 4'd3, 4'd8);
    addv(1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 4'd0, 4'd0);
    addv(1'b0, 1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd1, 4'd0);

    step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, none);
    step("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, none);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), 1'b0, vecs[i].s, vecs[i].f, vecs[i].m,
           vecs[i].c, vecs[i].d, vecs[i].v, 1'b1, vecs[i].e);

    // bubble counter saturation, then clear beats the increment
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_b%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 1'b1, 1'b0, none);
    step("clr_with_stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, none);
    step("reload", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h23, 1'b1, 1'b0, none);

    // freeze counter saturation with a pending flush; clear mid-miss keeps it
    for (int i = 0; i < 18; i++)
      step($sformatf("sat_f%0d", i), 1'b0, 1'b0, (i == 3), 1'b1, 1'b0, 8'h24, 1'b1, 1'b0, none);
    step("clr_in_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 1'b1, 1'b0, none);
    step("reset_mid_miss", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h26, 1'b1, 1'b0, none);
    step("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h27, 1'b1, 1'b0, none);

    for (int i = 0; i < 300; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
           8'($urandom), 1'($urandom), 1'b0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
